// File: rtl/alu_mul_sequencer_if.sv
// Handshake and shared-ALU bundle for the shift-add multiply sequencer.
// The slave modport is the sequencer; the master modport is the control unit plus ALU.
interface alu_mul_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [1:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_out;

  modport slave (
    input  start, op_a, op_b, alu_out,
    output busy, done, result_hi, result_lo, alu_a, alu_b, alu_ctrl
  );

  modport master (
    output start, op_a, op_b, alu_out,
    input  busy, done, result_hi, result_lo, alu_a, alu_b, alu_ctrl
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned WIDTH x WIDTH shift-add multiplier using the shared ALU for one add per cycle.
// Latency WIDTH+1 cycles from accepted start to done; start ignored while busy. Option: ALU_SEQ_ZERO_SKIP_EN.
module alu_mul_sequencer #(
  parameter int         WIDTH   = 32,
  parameter logic [1:0] ALU_ADD = 2'b00
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_mul_sequencer_if.slave   bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q,  state_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [CW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;

  logic [WIDTH-1:0] alu_a_w;
  logic [WIDTH-1:0] alu_b_w;
  logic [WIDTH-1:0] sum_w;
  logic             carry_w;
  logic [WIDTH-1:0] nxt_hi_w;
  logic [WIDTH-1:0] nxt_lo_w;

  // The ALU is only driven with live data in RUN so it sees quiet inputs otherwise.
  assign alu_a_w  = (state_q == RUN) ? hi_q : '0;
  assign alu_b_w  = (state_q == RUN && lo_q[0]) ? mcand_q : '0;
  assign sum_w    = bus.alu_out;
  // The ALU has no carry out; an unsigned add wrapped iff the sum is below an addend.
  assign carry_w  = (sum_w < alu_a_w);
  assign nxt_hi_w = {carry_w, sum_w[WIDTH-1:1]};
  assign nxt_lo_w = {sum_w[0], lo_q[WIDTH-1:1]};

  assign bus.alu_a     = alu_a_w;
  assign bus.alu_b     = alu_b_w;
  assign bus.alu_ctrl  = ALU_ADD;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d = bus.op_a;
          lo_d    = bus.op_b;
          hi_d    = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef ALU_SEQ_ZERO_SKIP_EN
          if (bus.op_a == '0 || bus.op_b == '0) begin
            res_hi_d = '0;
            res_lo_d = '0;
            state_d  = DONE;
          end
`endif
        end
      end

      RUN: begin
        hi_d  = nxt_hi_w;
        lo_d  = nxt_lo_w;
        cnt_d = cnt_q + CW'(1);
        // Results are captured on the edge that enters DONE so they are valid with done.
        if (cnt_q == CW'(WIDTH - 1)) begin
          res_hi_d = nxt_hi_w;
          res_lo_d = nxt_lo_w;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: directed corner cases plus random operands against a plain 64-bit multiply.
// Honours ALU_SEQ_ZERO_SKIP_EN for the expected zero-operand latency.
module tb_alu_mul_sequencer;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [63:0] prev_prod;

  alu_mul_sequencer_if #(.WIDTH(W)) bus ();

  alu_mul_sequencer #(.WIDTH(W), .ALU_ADD(2'b00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural ALU: add only; any other code yields a poison value.
  assign bus.alu_out = (bus.alu_ctrl == 2'b00) ? (bus.alu_a + bus.alu_b) : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_mul(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [63:0] exp_prod;
    int lat;
    int exp_lat;
    exp_prod = {32'd0, a} * {32'd0, b};
    exp_lat  = 33;
`ifdef ALU_SEQ_ZERO_SKIP_EN
    if (a == 0 || b == 0) exp_lat = 1;
`endif
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    check({tag, " busy_after_start"}, 64'(bus.busy), 64'd1);
    while (!bus.done && lat < 100) begin
      if (lat == 16) begin
        check({tag, " result_held_mid_run"}, {bus.result_hi, bus.result_lo}, prev_prod);
        check({tag, " alu_ctrl_run"}, 64'(bus.alu_ctrl), 64'd0);
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " product"}, {bus.result_hi, bus.result_lo}, exp_prod);
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 64'(bus.done), 64'd0);
    check({tag, " idle_after"}, {63'd0, bus.busy}, 64'd0);
    check({tag, " alu_idle"}, {bus.alu_a, bus.alu_b}, 64'd0);
    check({tag, " result_stable"}, {bus.result_hi, bus.result_lo}, exp_prod);
    prev_prod = exp_prod;
  endtask

  initial begin
    int done_cnt;
    int lat;
    int first_lat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    tests     = 0;
    fails     = 0;
    prev_prod = '0;
    done_cnt  = 0;
    first_lat = 0;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    rst_n     = 1'b0;

    // Reset state
    #12;
    check("rst_busy",   64'(bus.busy), 64'd0);
    check("rst_done",   64'(bus.done), 64'd0);
    check("rst_result", {bus.result_hi, bus.result_lo}, 64'd0);
    check("rst_alu_ab", {bus.alu_a, bus.alu_b}, 64'd0);
    check("rst_alu_ctrl", 64'(bus.alu_ctrl), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed products
    do_mul(32'd7, 32'd6, "mul_7x6");
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
    check("max_hi", 64'(bus.result_hi), 64'h0000_0000_FFFF_FFFE);
    check("max_lo", 64'(bus.result_lo), 64'h0000_0000_0000_0001);
    do_mul(32'h8000_0000, 32'd2, "mul_msb_x2");
    do_mul(32'd0, 32'h1234, "mul_zero_a");
    do_mul(32'h1234, 32'd0, "mul_zero_b");

    // Start pulsed mid-run must be ignored, and only one done may appear
    bus.op_a  = 32'd7;
    bus.op_b  = 32'd6;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 70; c++) begin
      if (c == 10) begin
        bus.op_a  = 32'd5;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.done) begin
        done_cnt++;
        if (first_lat == 0) first_lat = c + 1;
      end
    end
    check("midrun_latency", 64'(first_lat), 64'd33);
    check("midrun_done_count", 64'(done_cnt), 64'd1);
    check("midrun_product", {bus.result_hi, bus.result_lo}, 64'd42);
    prev_prod = 64'd42;

    // Start presented only during the done cycle must be ignored
    bus.op_a  = 32'd3;
    bus.op_b  = 32'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("donecyc_first_product", {bus.result_hi, bus.result_lo}, 64'd9);
    bus.op_a  = 32'd11;
    bus.op_b  = 32'd11;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("donecyc_start_ignored", 64'(bus.busy), 64'd0);
    prev_prod = 64'd9;

    // Async reset partway through a run
    bus.op_a  = 32'd9;
    bus.op_b  = 32'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy",   64'(bus.busy), 64'd0);
    check("abort_done",   64'(bus.done), 64'd0);
    check("abort_result", {bus.result_hi, bus.result_lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (bus.done) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'd0);
    prev_prod = 64'd0;
    do_mul(32'd3, 32'd4, "mul_after_abort");

    // Random operands, with occasional zero / all-ones corners
    for (int i = 0; i < 20; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = '0;
        1: rb = '1;
        2: rb = 32'($urandom_range(0, 15));
        default: ;
      endcase
      do_mul(ra, rb, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
